// File: rtl/chan_select_arb_pkg.sv
// ---------------------------------------------------------------------------
// chan_select_arb_pkg
//
// Shared constants and helpers for the channel selector / arbiter slice.
//   ARB_FIXED / ARB_RR : arbitration mode selectors for the ARB_MODE parameter
//   CNT_W              : width of the completed-transfer counter
//   clog2Floor1()      : channel index width, never narrower than one bit
// ---------------------------------------------------------------------------
package chan_select_arb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int CNT_W     = 8;

    // A two-channel selector still needs one index bit, so the result is
    // clamped to 1 for any channel count of 2 or fewer.
    function automatic int clog2Floor1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/chan_select_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Combinational one-hot arbiter with a registered round-robin pointer.
// Ports:
//   clk_i, rst_i  : clock and synchronous active-high reset
//   i_req         : per-channel request (already masked by the caller)
//   i_advance     : a grant was actually accepted this cycle
//   i_winner      : index of the accepted channel, used to move the pointer
//   o_grant       : one-hot grant, zero when nothing is requesting
//   o_grantIdx    : binary index of the granted channel
// ---------------------------------------------------------------------------
module rr_arbiter
    import chan_select_arb_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  ARB_MODE = ARB_RR,
    localparam int CH_W     = clog2Floor1(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    input  logic [CH_W-1:0]   i_winner,
    output logic [NUM_CH-1:0] o_grant,
    output logic [CH_W-1:0]   o_grantIdx
);

    logic [CH_W-1:0] r_ptr;
    logic [CH_W-1:0] w_base;
    logic [CH_W-1:0] w_idx;
    logic            w_found;

    // Fixed priority is simply a round-robin search that always starts at 0.
    assign w_base = (ARB_MODE == ARB_RR) ? r_ptr : '0;

    // Walk the channels starting at the search base, wrapping at NUM_CH,
    // and grant the first requester found. Only the first hit is kept.
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        w_idx      = '0;
        w_found    = 1'b0;
        for (int off = 0; off < NUM_CH; off++) begin
            w_idx = CH_W'((int'(w_base) + off) % NUM_CH);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grantIdx     = w_idx;
            end
        end
    end

    // The pointer moves one past the accepted channel so that channel gets
    // the lowest priority next time. It only moves on a real accept, so a
    // stalled output or an idle input leaves the rotation where it was.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if ((ARB_MODE == ARB_RR) && i_advance) begin
            if (i_winner == CH_W'(NUM_CH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= i_winner + CH_W'(1);
            end
        end
    end

endmodule

// File: rtl/chan_select_arb.sv
// ---------------------------------------------------------------------------
// chan_select_arb
//
// Runtime-arbitrated N-to-1 channel selector with a single registered output
// stage and valid/ready backpressure on both sides.
// Ports:
//   clk_i, rst_i  : clock and synchronous active-high reset
//   in_valid_i    : per-channel valid
//   in_data_i     : channel k data at [k*DATA_W +: DATA_W]
//   in_ready_o    : per-channel ready, one-hot or zero
//   out_valid_o   : output register holds a word
//   out_ready_i   : consumer accepts the word
//   out_data_o    : captured data word
//   out_ch_o      : channel the captured word came from
//   cnt_o         : completed output handshakes, modulo 256
// ---------------------------------------------------------------------------
module chan_select_arb
    import chan_select_arb_pkg::*;
#(
    parameter int                NUM_CH   = 4,
    parameter int                DATA_W   = 4,
    parameter logic [NUM_CH-1:0] CH_MASK  = '1,
    parameter int                ARB_MODE = ARB_RR,
    localparam int               CH_W     = clog2Floor1(NUM_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [CH_W-1:0]          out_ch_o,
    output logic [CNT_W-1:0]         cnt_o
);

    logic [NUM_CH-1:0] w_eligible;
    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_grantIdx;
    logic              w_take;
    logic              w_accept;
    logic              w_handshake;
    logic [DATA_W-1:0] w_selData;

    logic              r_outValid;
    logic [DATA_W-1:0] r_outData;
    logic [CH_W-1:0]   r_outCh;
    logic [CNT_W-1:0]  r_cnt;

    // Statically disabled channels are removed before arbitration, so they
    // can never win and never see ready.
    assign w_eligible = in_valid_i & CH_MASK;

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arbiter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_req      (w_eligible),
        .i_advance  (w_accept),
        .i_winner   (w_grantIdx),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx)
    );

    // The register can take a new word when it is empty or being drained
    // this very cycle, which is what gives one word per cycle throughput.
    // Ready is forced low while reset is asserted so nothing is consumed
    // from a producer in a cycle whose capture would be thrown away.
    assign w_take      = ~r_outValid | out_ready_i;
    assign in_ready_o  = w_grant & {NUM_CH{w_take & ~rst_i}};
    assign w_accept    = |in_ready_o;
    assign w_handshake = r_outValid & out_ready_i;

    // One-hot AND-OR data mux driven by the grant, so in_data_i only ever
    // reaches the output through the register.
    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant[k]) begin
                w_selData = in_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Output stage: a new accept always reloads, even when the current word
    // is leaving in the same cycle; otherwise a handshake empties it. The
    // counter tracks handshakes independently of whether a reload happened.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_outValid <= 1'b1;
                r_outData  <= w_selData;
                r_outCh    <= w_grantIdx;
            end else if (w_handshake) begin
                r_outValid <= 1'b0;
            end
            if (w_handshake) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid_o = r_outValid;
    assign out_data_o  = r_outData;
    assign out_ch_o    = r_outCh;
    assign cnt_o       = r_cnt;

endmodule
